// File: rtl/sqrt_req_scheduler_if.sv
// sqrt_req_scheduler_if: requester, engine and result signals of the shared square-root scheduler.
// Ports (slave = scheduler view):
//   req/req_x in, req_ack out        : requester level requests, packed operands, one-hot grant pulse
//   eng_start/eng_x/eng_abort out    : engine start pulse, latched operand, timeout clear
//   eng_done/eng_root in             : engine completion pulse and root
//   res_valid/res_id/res_root/res_err out, res_ready in : result handshake
//   busy out                         : scheduler not idle
interface sqrt_req_scheduler_if #(
    parameter int ID_W   = 2,
    parameter int DATA_W = 8,
    parameter int ROOT_W = 4
);
    localparam int NREQ = 2 ** ID_W;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_x;
    logic [NREQ-1:0]        req_ack;
    logic                   eng_start;
    logic [DATA_W-1:0]      eng_x;
    logic                   eng_abort;
    logic                   eng_done;
    logic [ROOT_W-1:0]      eng_root;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [ROOT_W-1:0]      res_root;
    logic                   res_err;
    logic                   busy;
    modport slave (
        input  req, req_x, eng_done, eng_root, res_ready,
        output req_ack, eng_start, eng_x, eng_abort, res_valid, res_id, res_root, res_err, busy
    );
    modport master (
        output req, req_x, eng_done, eng_root, res_ready,
        input  req_ack, eng_start, eng_x, eng_abort, res_valid, res_id, res_root, res_err, busy
    );
endinterface

// File: rtl/sqrt_req_scheduler.sv
// sqrt_req_scheduler: round-robin sharing of one square-root engine among 2**ID_W requesters.
// Ports:
//   clk   in : rising-edge clock
//   clr_n in : asynchronous active-low reset
//   bus   slave modport of sqrt_req_scheduler_if (requests/grants, engine start/done/abort,
//         result valid/ready with id, root and timeout error, busy)
module sqrt_req_scheduler #(
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8,
    parameter int ROOT_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                clr_n,
    sqrt_req_scheduler_if.slave bus
);
    localparam int NREQ = 2 ** ID_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, r_id, w_pick;
    logic              w_any, w_timeout;
    logic [7:0]        r_wdog;
    logic [NREQ-1:0]   r_req_ack;
    logic              r_eng_start, r_eng_abort, r_res_err;
    logic [DATA_W-1:0] r_eng_x;
    logic [ROOT_W-1:0] r_res_root;

    // The abort is registered, so it is decided one count early: the WAIT cycle that
    // would take the watchdog to TIMEOUT-1 is the last one.
    assign w_timeout = r_wdog == 8'(TIMEOUT - 2);

    // Scan downward in distance so the requester closest to rr_ptr (with wrap) wins.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[r_rr_ptr + ID_W'(k)]) begin
                w_pick = r_rr_ptr + ID_W'(k);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = (bus.eng_done || w_timeout) ? RESP : WAIT;
            RESP:    w_state_nxt = bus.res_ready ? IDLE : RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_wdog      <= '0;
            r_req_ack   <= '0;
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            r_eng_x     <= '0;
            r_res_root  <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_req_ack   <= '0;
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_req_ack <= NREQ'(1) << w_pick;
                    r_id      <= w_pick;
                    r_eng_x   <= bus.req_x[int'(w_pick) * DATA_W +: DATA_W];
                end
                ISSUE: begin
                    r_eng_start <= 1'b1;
                    r_wdog      <= '0;
                end
                WAIT: if (bus.eng_done) begin
                    r_res_root <= bus.eng_root;
                    r_res_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_eng_abort <= 1'b1;
                    r_res_root  <= '0;
                    r_res_err   <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 8'd1;
                end
                RESP: if (bus.res_ready) r_rr_ptr <= r_id + ID_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ack   = r_req_ack;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_x     = r_eng_x;
    assign bus.eng_abort = r_eng_abort;
    assign bus.res_valid = r_state == RESP;
    assign bus.res_id    = r_id;
    assign bus.res_root  = r_res_root;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// tb_sqrt_req_scheduler: scoreboard bench for the round-robin square-root scheduler.
module tb_sqrt_req_scheduler;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    sqrt_req_scheduler_if #(.ID_W(2), .DATA_W(8), .ROOT_W(4)) bus ();
    sqrt_req_scheduler #(.ID_W(2), .DATA_W(8), .ROOT_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .clr_n(clr_n), .bus(bus)
    );

    typedef struct {logic [1:0] id; logic [3:0] root; logic err;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, eng_lat = 10, aborts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] isqrt(input logic [7:0] x);
        for (int r = 15; r >= 0; r--) if (r * r <= int'(x)) return 4'(r);
        return 4'd0;
    endfunction

    // Engine model: done pulse in WAIT cycle eng_lat after the start pulse; eng_lat=0 never answers.
    initial begin
        bus.eng_done = 1'b0;
        bus.eng_root = '0;
        forever begin
            @(negedge clk);
            if (bus.eng_start && eng_lat > 0) begin
                repeat (eng_lat - 1) @(negedge clk);
                bus.eng_done = 1'b1;
                bus.eng_root = isqrt(bus.eng_x);
                @(negedge clk);
                bus.eng_done = 1'b0;
                bus.eng_root = '0;
            end
        end
    end

    // Monitor: every result handshake is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.eng_abort) aborts++;
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d root=%0d err=%0d expected none",
                             bus.res_id, bus.res_root, bus.res_err);
                end else begin
                    e = sb.pop_front();
                    chk("result{id,root,err}", {bus.res_id, bus.res_root, bus.res_err}, {e.id, e.root, e.err});
                end
            end
        end
    end

    task automatic post(input int id, input logic [7:0] x, input logic [3:0] root, input logic err);
        exp_t e;
        e = '{2'(id), root, err};
        bus.req_x[id*8 +: 8] = x;
        bus.req[id] = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int id, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ack == '0 && n < 300);
        chk(name, 32'(bus.req_ack), 32'(1) << id);
    endtask

    task automatic drop(input int id);
        @(posedge clk);
        #1 bus.req[id] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.busy) && n < 500);
        chk(name, {sb.size() != 0, bus.busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, a0;
        bus.req = '0;
        bus.req_x = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.req_ack, bus.eng_start, bus.eng_x, bus.eng_abort, bus.res_valid,
                              bus.res_id, bus.res_root, bus.res_err, bus.busy}, 0);
        clr_n = 1'b1;

        // 1: single request, 49 -> 7
        @(posedge clk); #1 post(0, 8'd49, 4'd7, 1'b0);
        wait_ack(0, "t1_ack");
        chk("t1_start_with_ack", bus.eng_start, 0);
        @(negedge clk);
        chk("t1_start{start,ack,x}", {bus.eng_start, bus.req_ack, bus.eng_x}, {1'b1, 4'b0, 8'd49});
        drop(0);
        wait_idle("t1_idle");
        chk("t1_eng_x_hold", bus.eng_x, 49);

        // 2: round robin; an id3 transaction first brings rr_ptr to 0
        @(posedge clk); #1 post(3, 8'd4, 4'd2, 1'b0);
        wait_ack(3, "t2_pre_ack");
        drop(3);
        wait_idle("t2_pre_idle");
        @(posedge clk); #1;
        post(0, 8'd16, 4'd4, 1'b0);
        post(2, 8'd81, 4'd9, 1'b0);
        sb.push_back('{2'd0, 4'd4, 1'b0});
        sb.push_back('{2'd2, 4'd9, 1'b0});
        wait_ack(0, "t2_ack0_a");
        wait_ack(2, "t2_ack2_a");
        wait_ack(0, "t2_ack0_b");
        wait_ack(2, "t2_ack2_b");
        @(posedge clk); #1 bus.req = '0;
        wait_idle("t2_held_idle");
        @(posedge clk); #1 post(0, 8'd1, 4'd1, 1'b0);
        wait_ack(0, "t2_rr1_ack");
        drop(0);
        wait_idle("t2_rr1_idle");
        @(posedge clk); #1;
        post(1, 8'd36, 4'd6, 1'b0);
        post(0, 8'd0, 4'd0, 1'b0);
        wait_ack(1, "t2_0011_first");
        drop(1);
        wait_ack(0, "t2_0011_second");
        drop(0);
        wait_idle("t2_idle");

        // 3: backpressure in RESP with another request pending
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        post(1, 8'd100, 4'd10, 1'b0);
        wait_ack(1, "t3_ack1");
        drop(1);
        post(3, 8'd225, 4'd15, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 100);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({bus.res_valid, bus.res_id, bus.res_root, bus.res_err, bus.busy, bus.req_ack} !==
                {1'b1, 2'd1, 4'd10, 1'b0, 1'b1, 4'b0}) bad++;
            @(negedge clk);
        end
        chk("t3_hold_bad_cycles", bad, 0);
        @(posedge clk); #1 bus.res_ready = 1'b1;
        wait_ack(3, "t3_next_grant");
        drop(3);
        wait_idle("t3_idle");

        // 4: timeout, then a normal request
        a0 = aborts;
        eng_lat = 0;
        @(posedge clk); #1 post(2, 8'd144, 4'd0, 1'b1);
        wait_ack(2, "t4_ack");
        drop(2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.eng_start && n < 10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.eng_abort && n < 200);
        chk("t4_wait_cycles_to_abort", n, 63);
        eng_lat = 10;
        @(posedge clk); #1 post(3, 8'd9, 4'd3, 1'b0);
        wait_ack(3, "t4_after_ack");
        drop(3);
        wait_idle("t4_idle");
        chk("t4_abort_pulses", aborts - a0, 1);

        // 5: done in WAIT cycle 63 beats the timeout
        a0 = aborts;
        eng_lat = 63;
        @(posedge clk); #1 post(1, 8'd64, 4'd8, 1'b0);
        wait_ack(1, "t5_ack");
        drop(1);
        wait_idle("t5_idle");
        chk("t5_no_abort", aborts - a0, 0);

        // 6: asynchronous reset in WAIT, in-flight request produces nothing
        eng_lat = 0;
        @(posedge clk); #1;
        bus.req_x[16 +: 8] = 8'd25;
        bus.req[2] = 1'b1;
        wait_ack(2, "t6_ack");
        drop(2);
        repeat (5) @(negedge clk);
        #2 clr_n = 1'b0;
        #1 chk("t6_async_reset_outputs", {bus.req_ack, bus.eng_start, bus.eng_x, bus.eng_abort, bus.res_valid,
                                         bus.res_id, bus.res_root, bus.res_err, bus.busy}, 0);
        @(negedge clk);
        eng_lat = 10;
        clr_n = 1'b1;
        @(posedge clk); #1 post(3, 8'd196, 4'd14, 1'b0);
        wait_ack(3, "t6_after_reset_ack");
        drop(3);
        wait_idle("t6_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
